fetch_stage: RTL and testbench

//  Instruction-fetch stage of each core's 5-stage pipeline. Owns the PC, drives
//  the instruction-memory/I-cache request, and absorbs multi-cycle hits.

---
 rtl/cpu_types_pkg.sv | 44 ++++
 rtl/fetch_ifid_reg.sv | 29 ++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, major opcodes, fetch FSM states and the IF/ID payload.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Major opcodes (instruction bits [31:26]); HALT freezes the fetch stage.
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_HALT  = 6'h3F
    } opcode_t;

    // FETCH: normal; DRAIN: redirect parked until the outstanding miss returns;
    // HALTED: frozen on a fetched HALT until an older redirect overrides it.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // IF/ID payload handed to decode.
    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t npc;
    } ifid_t;

    localparam word_t INSTR_BYTES = 32'd4;

    function automatic logic is_halt(input word_t w);
        return w[31:26] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline latch: load a new fetched entry, flush it to a bubble, or hold.
// Latency: 1 cycle from load to visible output.
// Backpressure: hold is implicit when neither load nor flush is asserted; load wins over flush.
module fetch_ifid_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  flush,
    input  ifid_t load_dat,
    output ifid_t ifid_dat,
    output logic  ifid_vld
);

    // Flush only drops the valid bit; the stale payload is harmless behind it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ifid_dat <= '0;
            ifid_vld <= 1'b0;
        end else if (load) begin
            ifid_dat <= load_dat;
            ifid_vld <= 1'b1;
        end else if (flush) begin
            ifid_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues I-cache reads, parks redirects behind misses, stops on HALT.
// Latency: an accepted word appears on ifid_* the cycle after the accepting edge.
// Backpressure: stall holds PC and IF/ID (a hit under stall is dropped and refetched); ~ihit inserts bubbles.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC0 = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        halted
);

    fetch_state_t state;
    word_t        pc;
    word_t        pend_pc;
    word_t        pc_inc;
    logic         accept;
    logic         ifid_load;
    logic         ifid_flush;
    ifid_t        ifid_new;
    ifid_t        ifid_q;

    assign pc_inc   = pc + INSTR_BYTES;
    assign accept   = ihit & ~stall & ~redirect;
    assign imemaddr = pc;
    assign iREN     = (state != HALTED);

    // IF/ID control: load only on an accepted hit in FETCH; every other non-holding case is a bubble.
    always_comb begin
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state)
            FETCH: begin
                ifid_load  = accept;
                ifid_flush = redirect | (~ihit & ~stall);
            end
            DRAIN:   ifid_flush = 1'b1;
            HALTED:  ifid_flush = redirect | ~stall;
            default: ifid_flush = 1'b1;
        endcase
    end

    assign ifid_new = '{instr: imemload, pc: pc, npc: pc_inc};

    fetch_ifid_reg u_ifid (
        .CLK      (CLK),
        .RST      (RST),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .load_dat (ifid_new),
        .ifid_dat (ifid_q),
        .ifid_vld (ifid_valid)
    );

    assign ifid_instr = ifid_q.instr;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_npc   = ifid_q.npc;

    // Fetch FSM: PC, parked redirect target and halted flag; priority redirect > stall > ihit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= FETCH;
            pc      <= PC0;
            pend_pc <= '0;
            halted  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if (ihit) begin
                            pc <= redirect_pc;
                        end else begin
                            // Keep PC steady so the in-flight fill completes for the same address.
                            pend_pc <= redirect_pc;
                            state   <= DRAIN;
                        end
                    end else if (accept) begin
                        if (is_halt(imemload)) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                DRAIN: begin
                    if (ihit) begin
                        pc    <= redirect ? redirect_pc : pend_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        pend_pc <= redirect_pc;
                    end
                end
                HALTED: begin
                    // The HALT was speculative: an older branch resolving here revives fetch.
                    if (redirect) begin
                        pc     <= redirect_pc;
                        halted <= 1'b0;
                        state  <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        halted;

    always #5 CLK = ~CLK;

    fetch_stage #(.PC0(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .imemload    (imemload),
        .iREN        (iREN),
        .imemaddr    (imemaddr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_npc    (ifid_npc),
        .ifid_valid  (ifid_valid),
        .halted      (halted)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Instruction memory image: ORI at 0, HALT at 0x3C, ADDI-like filler elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0)  return 32'h3401D269;
        if (a == 32'h3C) return 32'hFFFFFFFF;
        return {6'h08, 10'h000, a[15:0]};
    endfunction

    // ---------------- Reference model (architectural view) ----------------
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];   // non-empty while a redirect is parked behind a miss
    logic        m_halted;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    task automatic model_reset();
        m_pc = 32'h0; m_pend.delete(); m_halted = 1'b0;
        m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0;
    endtask

    task automatic model_step(input logic ih, input logic st, input logic rd,
                              input logic [31:0] rpc, input logic [31:0] word);
        if (m_halted) begin
            if (rd) begin
                m_pc = rpc; m_valid = 1'b0; m_halted = 1'b0;
            end else if (!st) begin
                m_valid = 1'b0;
            end
        end else if (m_pend.size() != 0) begin
            m_valid = 1'b0;
            if (ih) begin
                m_pc = rd ? rpc : m_pend[0];
                m_pend.delete();
            end else if (rd) begin
                m_pend[0] = rpc;
            end
        end else if (rd) begin
            m_valid = 1'b0;
            if (ih) m_pc = rpc;
            else    m_pend.push_back(rpc);
        end else if (!st) begin
            if (ih) begin
                m_valid = 1'b1; m_instr = word; m_ipc = m_pc;
                if (word[31:26] == 6'h3F) m_halted = 1'b1;
                else                      m_pc = m_pc + 32'd4;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_addr"},   imemaddr, m_pc);
        check({tag, "_iren"},   {31'h0, iREN}, {31'h0, ~m_halted});
        check({tag, "_halted"}, {31'h0, halted}, {31'h0, m_halted});
        check({tag, "_valid"},  {31'h0, ifid_valid}, {31'h0, m_valid});
        if (m_valid) begin
            check({tag, "_ipc"},   ifid_pc, m_ipc);
            check({tag, "_instr"}, ifid_instr, m_instr);
            check({tag, "_npc"},   ifid_npc, m_ipc + 32'd4);
        end
    endtask

    // One clock: drive inputs (memory answers for the model's PC), step model, sample after edge.
    task automatic cycle(input logic ih, input logic st, input logic rd, input logic [31:0] rpc,
                         input string tag);
        logic [31:0] w;
        w = imem(m_pc);
        ihit = ih; stall = st; redirect = rd; redirect_pc = rpc; imemload = w;
        model_step(ih, st, rd, rpc, w);
        @(posedge CLK);
        #1;
        check_model(tag);
    endtask

    // ---------------- Directed vector table ----------------
    typedef struct {
        logic        ih;
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_halt;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // programme run, miss bubbles, redirect under miss, stall, run to HALT
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h00, 32'h04, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h08, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 32'h08, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 32'h08, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 32'h08, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'h0C, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h10, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h00, 32'h10, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 32'h10, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 32'h20, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h20, 32'h24, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 32'h24, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 32'h24, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h24, 32'h28, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h28, 32'h2C, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h2C, 32'h30, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h30, 32'h34, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h34, 32'h38, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h38, 32'h3C, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h3C, 32'h3C, 1'b1};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h3C, 32'h3C, 1'b1};

        RST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imemload = 32'h0;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);

        // reset state
        check("rst_addr",   imemaddr, 32'h0);
        check("rst_iren",   {31'h0, iREN}, 32'h1);
        check("rst_valid",  {31'h0, ifid_valid}, 32'h0);
        check("rst_instr",  ifid_instr, 32'h0);
        check("rst_ipc",    ifid_pc, 32'h0);
        check("rst_npc",    ifid_npc, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        RST = 1'b0;

        // directed table
        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].ih, tbl[i].st, tbl[i].rd, tbl[i].rpc, $sformatf("v%0d_m", i));
            check($sformatf("v%0d_valid", i), {31'h0, ifid_valid}, {31'h0, tbl[i].e_valid});
            check($sformatf("v%0d_addr", i), imemaddr, tbl[i].e_addr);
            check($sformatf("v%0d_halted", i), {31'h0, halted}, {31'h0, tbl[i].e_halt});
            check($sformatf("v%0d_iren", i), {31'h0, iREN}, {31'h0, ~tbl[i].e_halt});
            if (tbl[i].e_valid) begin
                check($sformatf("v%0d_ipc", i), ifid_pc, tbl[i].e_pc);
                check($sformatf("v%0d_instr", i), ifid_instr, imem(tbl[i].e_pc));
                check($sformatf("v%0d_npc", i), ifid_npc, tbl[i].e_pc + 32'd4);
            end
        end
        check("halt_ipc_kept", ifid_pc, 32'h3C);

        // redirect beats stall while halted
        cycle(1'b0, 1'b1, 1'b1, 32'h100, "unhalt");
        check("unhalt_halted", {31'h0, halted}, 32'h0);
        check("unhalt_iren",   {31'h0, iREN}, 32'h1);
        check("unhalt_addr",   imemaddr, 32'h100);

        // enter DRAIN, then asynchronous reset aborts it
        cycle(1'b0, 1'b0, 1'b1, 32'h200, "drain_in");
        check("drain_addr_held", imemaddr, 32'h100);
        RST = 1'b1;
        #2;
        check("arst_addr",  imemaddr, 32'h0);
        check("arst_valid", {31'h0, ifid_valid}, 32'h0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0, "post_rst");
        check("post_rst_ipc",  ifid_pc, 32'h0);
        check("post_rst_addr", imemaddr, 32'h4);

        // PC+4 wrap at the top of the address space
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, "wrap_rd");
        cycle(1'b1, 1'b0, 1'b0, 32'h0, "wrap");
        check("wrap_ipc",  ifid_pc, 32'hFFFF_FFFC);
        check("wrap_npc",  ifid_npc, 32'h0);
        check("wrap_addr", imemaddr, 32'h0);

        // second redirect during DRAIN replaces the parked target
        cycle(1'b0, 1'b0, 1'b1, 32'h40, "dd1");
        cycle(1'b0, 1'b0, 1'b1, 32'h80, "dd2");
        cycle(1'b1, 1'b0, 1'b0, 32'h0,  "dd3");
        check("dd_addr",  imemaddr, 32'h80);
        check("dd_valid", {31'h0, ifid_valid}, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic ih, st, rd;
            logic [31:0] rpc;
            ih  = ($urandom_range(0, 99) < 70);
            st  = ($urandom_range(0, 99) < 25);
            rd  = ($urandom_range(0, 99) < 10);
            rpc = 32'($urandom_range(0, 20)) * 32'd4;
            cycle(ih, st, rd, rpc, $sformatf("r%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
